aes_decryption_ctrl: RTL
========================

AES_DECRYPTION_CTRL -- requirements
Module: aes_decryption_ctrl

Interface
REQ-001 SHALL have one clock, clk_in; reset is asynchronous and active-high, rst_in.
REQ-002 Ports, as name direction width meaning:
- clk_in  in  1  clock
- rst_in  in  1  async active-high reset
- key_wr_en  in  1  round-key write strobe
- key_wr_idx  in  4  round-key index 0..10
- key_wr_data  in  128  round key
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  controller accepts a block
- in_data  in  128  ciphertext
- out_valid  out  1  plaintext block held
- out_ready  in  1  downstream accepts
- out_data  out  128  plaintext
- core_init_out  out  1  start pulse to the decryption core
- core_data_out  out  128  block to the core
- core_key_out  out  128  round key to the core
- core_round_out  out  4  round number to the core
- core_next_round_in  in  1  core round-advance indication
- core_data_in  in  128  core result
- core_valid_in  in  1  core result valid
- keys_loaded  out  1  all 11 round keys written
- blocks_done  out  16  count of completed blocks

Function
REQ-003 SHALL have states IDLE, LOAD, RUN and HOLD.
- IDLE->LOAD on in_valid&&in_ready.
- LOAD->RUN after one cycle.
- RUN->HOLD on core_valid_in.
- HOLD->IDLE on out_ready.
REQ-004 in_ready SHALL equal (state==IDLE)&&keys_loaded.
REQ-005 On acceptance, in_data SHALL be registered into core_data_out; core_round_out SHALL be set to 0.
REQ-006 core_init_out SHALL be high for exactly the one LOAD cycle and low otherwise.
REQ-007 core_key_out SHALL be combinational rk[10-core_round_out], so round 0 uses rk[10] and round 10 uses rk[0].
REQ-008 In RUN, core_round_out SHALL increment by 1 on each edge where core_next_round_in=1.
REQ-009 core_round_out SHALL saturate at 10, and SHALL NOT exceed 10 even on a spurious core_next_round_in.
REQ-010 On the edge core_valid_in=1 in RUN, core_data_in SHALL be captured into out_data; out_valid SHALL then be 1 and blocks_done SHALL increment.
REQ-011 blocks_done SHALL wrap from 0xFFFF to 0.
REQ-012 out_valid/out_data SHALL stay stable in HOLD until out_ready=1.
REQ-013 The transfer SHALL complete on the edge where out_valid&&out_ready, and out_valid SHALL deassert after that edge.
REQ-014 A new block SHALL NOT be accepted in the HOLD->IDLE cycle; the minimum block period is 44 cycles.
REQ-015 Latency SHALL be exactly 42 cycles from the acceptance edge to the first cycle of out_valid=1.
REQ-016 Key writes with key_wr_idx<=10 SHALL be accepted only in IDLE.
REQ-017 Key writes in LOAD/RUN/HOLD, or with key_wr_idx>10, SHALL be ignored.
REQ-018 An 11-bit written-mask SHALL track the round keys; keys_loaded=&mask. Rewriting an index SHALL update its key and leave the mask set.
REQ-019 core_valid_in outside RUN SHALL be ignored.
REQ-020 in_valid while not ready SHALL be ignored; in_data SHALL NOT be sampled.

Reset
REQ-021 On rst_in: state=IDLE, core_round_out=0, core_init_out=0, out_valid=0, written-mask=0, blocks_done=0; keys_loaded and in_ready SHALL therefore be 0.
REQ-022 Round-key, core_data_out and out_data storage SHALL NOT require reset.
REQ-023 Reset asserted mid-RUN or mid-HOLD SHALL abort the block with no out_valid pulse; all 11 keys SHALL be reloaded before the next block.

Structure
REQ-024 Round encoding ROUND_INIT..ROUND_10 (0..10), NUM_ROUND_KEYS=11 and the controller state enum SHALL live in the shared aes_defs package.
REQ-025 The round-key store (11x128, one write port, one async read port) SHALL be a sub-module aes_round_key_store; all other logic SHALL be inline.

Verification
REQ-026 Load FIPS-197 AES-128 expanded keys: rk[0]=000102030405060708090a0b0c0d0e0f, rk[10]=13111d7fe3944a17f307a78b4d2b30c5. Send ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, out_valid 42 cycles after acceptance, blocks_done=1.
REQ-027 Write keys 0..9 only -> keys_loaded=0 and in_ready=0. Write key 10 -> in_ready=1 the next cycle.
REQ-028 Hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0. Raise out_ready -> one transfer, in_ready=1 one cycle later.
REQ-029 Key write to idx 10 during RUN -> ignored; the block decrypts correctly; a rerun gives the same plaintext.
REQ-030 Assert rst_in when core_round_out=5 -> all outputs at their reset values immediately (async), no out_valid, keys_loaded=0.
REQ-031 Force core_next_round_in high continuously -> core_round_out=10 and no higher; preload blocks_done=0xFFFF, complete one block -> blocks_done=0.

Source files
------------

// File: rtl/aes_decryption_ctrl_pkg.sv
// Shared definitions for the AES decryption controller: round encoding,
// key-store sizing and the controller state enum.
package aes_defs;

    localparam int NUM_ROUND_KEYS = 11;
    localparam int BLOCK_W        = 128;

    typedef enum logic [3:0] {
        ROUND_INIT = 4'd0,
        ROUND_1    = 4'd1,
        ROUND_2    = 4'd2,
        ROUND_3    = 4'd3,
        ROUND_4    = 4'd4,
        ROUND_5    = 4'd5,
        ROUND_6    = 4'd6,
        ROUND_7    = 4'd7,
        ROUND_8    = 4'd8,
        ROUND_9    = 4'd9,
        ROUND_10   = 4'd10
    } round_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } ctrl_state_e;

    // Decryption walks the expanded key schedule backwards.
    function automatic logic [3:0] key_idx_for_round(input logic [3:0] round);
        return 4'(ROUND_10) - round;
    endfunction

endpackage

// File: rtl/aes_decryption_ctrl_if.sv
// Bundle of key-load, block handshake and core-side signals of the controller.
// Handshakes: a transfer happens on the clock edge where valid && ready are both 1.
interface aes_decryption_ctrl_if;

    logic         key_wr_en;
    logic [3:0]   key_wr_idx;
    logic [127:0] key_wr_data;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;

    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic         core_init_out;
    logic [127:0] core_data_out;
    logic [127:0] core_key_out;
    logic [3:0]   core_round_out;
    logic         core_next_round_in;
    logic [127:0] core_data_in;
    logic         core_valid_in;

    logic         keys_loaded;
    logic [15:0]  blocks_done;

    modport slave (
        input  key_wr_en, key_wr_idx, key_wr_data,
        input  in_valid, in_data, out_ready,
        input  core_next_round_in, core_data_in, core_valid_in,
        output in_ready, out_valid, out_data,
        output core_init_out, core_data_out, core_key_out, core_round_out,
        output keys_loaded, blocks_done
    );

    modport master (
        output key_wr_en, key_wr_idx, key_wr_data,
        output in_valid, in_data, out_ready,
        output core_next_round_in, core_data_in, core_valid_in,
        input  in_ready, out_valid, out_data,
        input  core_init_out, core_data_out, core_key_out, core_round_out,
        input  keys_loaded, blocks_done
    );

endinterface

// File: rtl/aes_round_key_store.sv
// Eleven-entry round-key memory: one synchronous write port, one async read port.
module aes_round_key_store
    import aes_defs::*;
(
    input  logic         clk_i,
    input  logic         wr_en_i,
    input  logic [3:0]   wr_idx_i,
    input  logic [127:0] wr_data_i,
    input  logic [3:0]   rd_idx_i,
    output logic [127:0] rd_data_o
);

    logic [127:0] key_q [NUM_ROUND_KEYS];

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (wr_idx_i < 4'(NUM_ROUND_KEYS))) begin
            key_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = (rd_idx_i < 4'(NUM_ROUND_KEYS)) ? key_q[rd_idx_i] : '0;

endmodule

// File: rtl/aes_decryption_ctrl.sv
// Sequences one ciphertext block through an external AES decryption core,
// supplying round keys in reverse order and buffering the plaintext result.
module aes_decryption_ctrl
    import aes_defs::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    aes_decryption_ctrl_if.slave  bus,
    output ctrl_state_e           state_dbg_o
);

    ctrl_state_e  state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [10:0]  mask_q, mask_d;
    logic [15:0]  blocks_done_q;
    logic [127:0] core_data_q;
    logic [127:0] out_data_q;

    logic         keys_loaded;
    logic         in_ready;
    logic         accept;
    logic         capture;
    logic         key_we;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    assign keys_loaded = &mask_q;
    assign in_ready    = (state_q == ST_IDLE) && keys_loaded;
    assign accept      = bus.in_valid && in_ready;
    assign capture     = (state_q == ST_RUN) && bus.core_valid_in;
    assign key_we      = bus.key_wr_en && (state_q == ST_IDLE) && (bus.key_wr_idx <= 4'(ROUND_10));
    assign rd_idx      = key_idx_for_round(round_q);

    aes_round_key_store u_key_store (
        .clk_i     (clk_in),
        .wr_en_i   (key_we),
        .wr_idx_i  (bus.key_wr_idx),
        .wr_data_i (bus.key_wr_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_key)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        mask_d  = mask_q;

        case (state_q)
            ST_IDLE: if (accept)             state_d = ST_LOAD;
            ST_LOAD:                         state_d = ST_RUN;
            ST_RUN:  if (bus.core_valid_in)  state_d = ST_HOLD;
            ST_HOLD: if (bus.out_ready)      state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase

        // Round counter saturates so a misbehaving core cannot index past rk[0].
        if (accept) begin
            round_d = 4'(ROUND_INIT);
        end else if ((state_q == ST_RUN) && bus.core_next_round_in && (round_q < 4'(ROUND_10))) begin
            round_d = round_q + 4'd1;
        end

        if (key_we) begin
            mask_d = mask_q | (11'd1 << bus.key_wr_idx);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            round_q       <= 4'(ROUND_INIT);
            mask_q        <= '0;
            blocks_done_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            mask_q  <= mask_d;
            if (capture) begin
                blocks_done_q <= blocks_done_q + 16'd1;
            end
        end
    end

    // Data-path registers carry no reset; their contents are qualified by the FSM.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            core_data_q <= bus.in_data;
        end
        if (capture) begin
            out_data_q <= bus.core_data_in;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.keys_loaded    = keys_loaded;
    assign bus.out_valid      = (state_q == ST_HOLD);
    assign bus.out_data       = out_data_q;
    assign bus.core_init_out  = (state_q == ST_LOAD);
    assign bus.core_data_out  = core_data_q;
    assign bus.core_key_out   = rd_key;
    assign bus.core_round_out = round_q;
    assign bus.blocks_done    = blocks_done_q;
    assign state_dbg_o        = state_q;

endmodule
